// File: rtl/trim_pkg.sv
// Shared types and helpers for the regulator trim calibrator.
package trim_pkg;

  localparam int TRIM_W = 4;

  // Signed trim as seen by the regulator, and the internal offset-binary search code.
  typedef logic signed [TRIM_W-1:0] trim_t;
  typedef logic        [TRIM_W-1:0] code_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DECIDE,
    ST_VERIFY_SETTLE,
    ST_VERIFY,
    ST_DONE
  } trim_state_e;

  // Search starts at mid-scale, which maps to trim 0.
  localparam code_t CODE_MID = code_t'(1) << (TRIM_W - 1);
  localparam code_t CODE_MIN = '0;
  localparam code_t CODE_MAX = '1;

  // Offset binary to two's complement: flipping the MSB recentres 0..15 onto -8..+7.
  function automatic trim_t code2trim(input code_t code);
    return trim_t'({~code[TRIM_W-1], code[TRIM_W-2:0]});
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags when the settle wait has elapsed.
// The count holds at zero, so it never wraps between loads.
module settle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down towards zero and stay there.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/regulator_trim_ctrl.sv
// Regulator trim calibrator: SAR search over trim -8..+7 using a comparator
// fed back from the regulator, with a settle wait after every trim change.
// The result is the largest trim for which vout is not above target.
// A manual override forces trim directly and aborts any search.
//
// Build option TRIM_CTRL_CMP_SYNC_EN: when defined, cmp_above passes through a
// 2-flop synchronizer before use (SETTLE_CYCLES must then be at least 3; the
// synchronizer delay hides inside the settle wait, so latency is unchanged).
// When undefined, cmp_above must already be synchronous to clk.
module regulator_trim_ctrl
  import trim_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmp_above,
  input  logic              manual_en,
  input  logic [TRIM_W-1:0] manual_trim,
  output logic [TRIM_W-1:0] trim,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  localparam int TIMER_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(SETTLE_CYCLES - 1);

  trim_state_e state;
  code_t       code;
  code_t       decide_code;
  logic [1:0]  bit_idx;
  logic        cmp_s;
  logic        timer_load;
  logic        timer_expired;

`ifdef TRIM_CTRL_CMP_SYNC_EN
  logic cmp_meta;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_meta <= 1'b0;
      cmp_s    <= 1'b0;
    end else begin
      cmp_meta <= cmp_above;
      cmp_s    <= cmp_meta;
    end
  end
`else
  assign cmp_s = cmp_above;
`endif

  // The settle wait restarts whenever the trim driven to the regulator changes.
  assign timer_load = !manual_en &&
                      (((state == ST_IDLE) && start) || (state == ST_DECIDE));

  settle_timer #(
    .W (TIMER_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (TIMER_RELOAD),
    .expired  (timer_expired)
  );

  // Next search code: drop the bit under test if vout was high, then tentatively set the next lower bit.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    decide_code = code;
    if (cmp_s) begin
      decide_code[bit_idx] = 1'b0;
    end
    if (bit_idx != 2'd0) begin
      decide_code[bit_idx - 2'd1] = 1'b1;
    end
  end

  // Search FSM with registered trim, busy, done and fail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      code    <= CODE_MID;
      bit_idx <= 2'd3;
      trim    <= code2trim(CODE_MID);
      busy    <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (manual_en) begin
        // Override wins over everything; fail is left as the last search set it.
        trim  <= manual_trim;
        busy  <= 1'b0;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              code    <= CODE_MID;
              trim    <= code2trim(CODE_MID);
              bit_idx <= 2'd3;
              fail    <= 1'b0;
              busy    <= 1'b1;
              state   <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (timer_expired) begin
              state <= ST_DECIDE;
            end
          end
          ST_DECIDE: begin
            code <= decide_code;
            trim <= code2trim(decide_code);
            if (bit_idx != 2'd0) begin
              bit_idx <= bit_idx - 2'd1;
              state   <= ST_SETTLE;
            end else begin
              state <= ST_VERIFY_SETTLE;
            end
          end
          ST_VERIFY_SETTLE: begin
            if (timer_expired) begin
              state <= ST_VERIFY;
            end
          end
          ST_VERIFY: begin
            // Result pinned at a range edge means the target lies outside the trim range.
            fail  <= ((code == CODE_MIN) && cmp_s) || ((code == CODE_MAX) && !cmp_s);
            state <= ST_DONE;
          end
          ST_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regulator_trim_ctrl.sv
// Self-checking bench for regulator_trim_ctrl with a behavioural regulator
// model: cmp_above = (trim >= threshold).
module tb_regulator_trim_ctrl;

  localparam int SC  = 4;
  localparam int LAT = 5 * (SC + 1) + 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              cmp_above;
  logic              manual_en;
  logic signed [3:0] manual_trim;
  logic signed [3:0] trim;
  logic              busy;
  logic              done;
  logic              fail;

  int t_thr;
  int vectors;
  int miscompares;
  int last_fail;

  regulator_trim_ctrl #(
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cmp_above   (cmp_above),
    .manual_en   (manual_en),
    .manual_trim (manual_trim),
    .trim        (trim),
    .busy        (busy),
    .done        (done),
    .fail        (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regulator model: vout is above target once trim reaches the threshold.
  assign cmp_above = (int'(trim) >= t_thr);

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Full calibration run from IDLE; optionally re-pulses start mid-search.
  task automatic run_search(input int thr, input int restart_at, input string tag);
    int seq[5];
    int lo;
    int hi;
    int mid;
    int exp_final;
    int exp_fail;
    int done_first;
    int done_n;
    // Reference: bisection over the trim interval [lo, hi) for the last trim below thr.
    lo = -8;
    hi = 8;
    for (int j = 0; j < 5; j++) begin
      mid = (lo + hi) / 2;
      if (j == 4) mid = lo;
      seq[j] = mid;
      if (j < 4) begin
        if (mid >= thr) hi = mid;
        else            lo = mid;
      end
    end
    exp_final = thr - 1;
    if (exp_final < -8) exp_final = -8;
    if (exp_final > 7)  exp_final = 7;
    exp_fail = (thr <= -8 || thr > 7) ? 1 : 0;
    done_first = -1;
    done_n = 0;

    t_thr = thr;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check({tag, "_trim0"}, int'(trim), seq[0]);
    for (int c = 1; c <= LAT + 8; c++) begin
      @(posedge clk); #1;
      if (c % (SC + 1) == 0 && c / (SC + 1) < 5)
        check($sformatf("%s_trim%0d", tag, c / (SC + 1)), int'(trim), seq[c / (SC + 1)]);
      if (c == 1) check({tag, "_busy_on"}, int'(busy), 1);
      if (done) begin
        if (done_n == 0) done_first = c;
        done_n++;
      end
      if (c == LAT) begin
        check({tag, "_final"}, int'(trim), exp_final);
        check({tag, "_fail"}, int'(fail), exp_fail);
        check({tag, "_busy_off"}, int'(busy), 0);
      end
      start = (c == restart_at);
    end
    start = 1'b0;
    check({tag, "_done_lat"}, done_first, LAT);
    check({tag, "_done_cnt"}, done_n, 1);
    last_fail = exp_fail;
  endtask

  initial begin
    int done_n;
    vectors = 0;
    miscompares = 0;
    last_fail = 0;
    t_thr = 3;
    rst_n = 1'b0;
    start = 1'b0;
    manual_en = 1'b0;
    manual_trim = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trim", int'(trim), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fail", int'(fail), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal search and range edges.
    run_search(3, -1, "t3");
    run_search(-100, -1, "stuck1");
    run_search(100, -1, "stuck0");
    // Start while busy is ignored.
    run_search(3, 8, "restart");
    // Boundary thresholds and random targets.
    run_search(-8, -1, "tm8");
    run_search(8, -1, "tp8");
    run_search(-2, -1, "tm2");
    for (int k = 0; k < 6; k++)
      run_search(int'($urandom_range(0, 19)) - 10, -1, $sformatf("rnd%0d", k));

    // Manual override mid-search.
    t_thr = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 manual_en = 1'b1;
    manual_trim = -4'sd5;
    @(posedge clk); #1;
    check("man_trim", int'(trim), -5);
    check("man_busy", int'(busy), 0);
    done_n = 0;
    start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) done_n++;
      if (c == 2) start = 1'b0;
    end
    check("man_no_done", done_n, 0);
    check("man_start_ign", int'(busy), 0);
    check("man_fail_hold", int'(fail), last_fail);
    manual_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("man_release_hold", int'(trim), -5);
    run_search(5, -1, "after_man");

    // Asynchronous reset during the bit-1 settle wait.
    t_thr = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2 * (SC + 1) + 2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_trim", int'(trim), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_search(3, -1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
